// File: rtl/bus_arbiter.sv
// Round-robin owner selection and drive-enable generation for a shared 3-state bus.
// Build option BUS_CAPTURE_EN adds cap_data/cap_valid, a register of dbus taken whenever bus_valid is high.
module bus_arbiter #(
  parameter int N        = 4,
  parameter int width    = 4,
  parameter int MAX_HOLD = 8,
  parameter int TURN_CYC = 1,
  localparam int IDW     = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic [width-1:0] dbus,
  output logic [N-1:0]     en,
  output logic [IDW-1:0]   grant_id,
  output logic             busy,
  output logic             bus_valid
`ifdef BUS_CAPTURE_EN
  ,
  output logic [width-1:0] cap_data,
  output logic             cap_valid
`endif
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam int TW = $clog2(TURN_CYC + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  localparam logic [HW-1:0] HOLD_SAT  = HW'(MAX_HOLD);
  localparam logic [TW-1:0] TURN_LAST = TW'(TURN_CYC - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] TURN  = 2'd2;

  logic [1:0]     state_reg, state_next;
  logic [N-1:0]   en_reg, en_next;
  logic [IDW-1:0] grant_reg, grant_next;
  logic [IDW-1:0] last_reg, last_next;
  logic [HW-1:0]  hold_reg, hold_next;
  logic [TW-1:0]  turn_reg, turn_next;

  logic           pick_valid;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] cand;
  logic           owner_req;
  logic           others_req;

  // Scan starts just after the previous owner so it gets the lowest priority.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 1; off <= N; off++) begin
      cand = IDW'((int'(last_reg) + off) % N);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  assign owner_req  = |(req & en_reg);
  assign others_req = |(req & ~en_reg);

  always_comb begin
    state_next = state_reg;
    en_next    = en_reg;
    grant_next = grant_reg;
    last_next  = last_reg;
    hold_next  = hold_reg;
    turn_next  = turn_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          en_next           = '0;
          en_next[pick_idx] = 1'b1;
          grant_next        = pick_idx;
          last_next         = pick_idx;
          hold_next         = '0;
          state_next        = GRANT;
        end
      end
      GRANT: begin
        if (!owner_req || ((hold_reg >= HOLD_LAST) && others_req)) begin
          en_next    = '0;
          turn_next  = '0;
          state_next = TURN;
        end else if (hold_reg < HOLD_SAT) begin
          hold_next = hold_reg + HW'(1);
        end
      end
      TURN: begin
        if (turn_reg >= TURN_LAST) begin
          if (pick_valid) begin
            en_next           = '0;
            en_next[pick_idx] = 1'b1;
            grant_next        = pick_idx;
            last_next         = pick_idx;
            hold_next         = '0;
            state_next        = GRANT;
          end else begin
            state_next = IDLE;
          end
        end else begin
          turn_next = turn_reg + TW'(1);
        end
      end
      default: begin
        en_next    = '0;
        state_next = IDLE;
      end
    endcase
  end

  // Async reset so a bus owner is cut off without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      en_reg    <= '0;
      grant_reg <= '0;
      last_reg  <= IDW'(N - 1);
      hold_reg  <= '0;
      turn_reg  <= '0;
    end else begin
      state_reg <= state_next;
      en_reg    <= en_next;
      grant_reg <= grant_next;
      last_reg  <= last_next;
      hold_reg  <= hold_next;
      turn_reg  <= turn_next;
    end
  end

  assign en        = en_reg;
  assign grant_id  = grant_reg;
  assign busy      = |en_reg;
  // Owner drives from the second edge after en rises, i.e. once hold_cnt has left 0.
  assign bus_valid = (state_reg == GRANT) && (hold_reg != '0);

`ifdef BUS_CAPTURE_EN
  logic [width-1:0] cap_data_reg;
  logic             cap_valid_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_data_reg  <= '0;
      cap_valid_reg <= 1'b0;
    end else if (bus_valid) begin
      cap_data_reg  <= dbus;
      cap_valid_reg <= 1'b1;
    end else begin
      cap_valid_reg <= 1'b0;
    end
  end

  assign cap_data  = cap_data_reg;
  assign cap_valid = cap_valid_reg;
`else
  logic dbus_unused;
  assign dbus_unused = ^dbus;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus queues per-edge expectations, a monitor checks them.
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] dbus;
  logic [3:0] en;
  logic [1:0] grant_id;
  logic       busy;
  logic       bus_valid;
`ifdef BUS_CAPTURE_EN
  logic [3:0] cap_data;
  logic       cap_valid;
`endif

  int checks   = 0;
  int failures = 0;
  int step_no  = 0;

  typedef struct {
    int         id;
    logic [3:0] en;
    logic [1:0] gid;
    logic       bv;
  } exp_t;

  exp_t exp_q[$];

  bus_arbiter #(.N(4), .width(4), .MAX_HOLD(8), .TURN_CYC(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .dbus      (dbus),
    .en        (en),
    .grant_id  (grant_id),
    .busy      (busy),
    .bus_valid (bus_valid)
`ifdef BUS_CAPTURE_EN
    ,
    .cap_data  (cap_data),
    .cap_valid (cap_valid)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, expv, $time);
    end
  endtask

  // Drive req before the next rising edge and queue what that edge must produce.
  task automatic step(input logic [3:0] r, input logic [3:0] e_en, input logic [1:0] e_gid,
                      input logic e_bv);
    exp_t e;
    @(negedge clk);
    req = r;
    step_no++;
    e.id = step_no; e.en = e_en; e.gid = e_gid; e.bv = e_bv;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("s%0d_en", e.id), 32'(en), 32'(e.en));
        chk($sformatf("s%0d_gid", e.id), 32'(grant_id), 32'(e.gid));
        chk($sformatf("s%0d_busy", e.id), 32'(busy), 32'(|e.en));
        chk($sformatf("s%0d_bv", e.id), 32'(bus_valid), 32'(e.bv));
        $display("step %0d req=%b en=%b gid=%0d busy=%b bv=%b", e.id, req, en, grant_id, busy, bus_valid);
      end
    end
  end

  initial begin : stim
    rst_n = 1'b0;
    req   = 4'b0000;
    dbus  = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_en", 32'(en), 32'h0);
    chk("rst_gid", 32'(grant_id), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_bv", 32'(bus_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // idle with no requests
    repeat (5) step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // users 1 and 2 contend: forced release after 8 cycles, 1-cycle gap
    step(4'b0110, 4'b0010, 2'd1, 1'b0);
    repeat (7) step(4'b0110, 4'b0010, 2'd1, 1'b1);
    step(4'b0110, 4'b0000, 2'd1, 1'b0);
    step(4'b0110, 4'b0100, 2'd2, 1'b0);
    repeat (7) step(4'b0110, 4'b0100, 2'd2, 1'b1);
    step(4'b0110, 4'b0000, 2'd2, 1'b0);
    step(4'b0110, 4'b0010, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);

    // lone requester keeps the bus past MAX_HOLD
    step(4'b1000, 4'b1000, 2'd3, 1'b0);
    repeat (19) step(4'b1000, 4'b1000, 2'd3, 1'b1);
    step(4'b0000, 4'b0000, 2'd3, 1'b0);
    step(4'b0000, 4'b0000, 2'd3, 1'b0);

    // owner 0 drops as user 2 raises; then previous owner loses to user 0 after TURN
    step(4'b0001, 4'b0001, 2'd0, 1'b0);
    step(4'b0001, 4'b0001, 2'd0, 1'b1);
    step(4'b0100, 4'b0000, 2'd0, 1'b0);
    step(4'b0100, 4'b0100, 2'd2, 1'b0);
    step(4'b0100, 4'b0100, 2'd2, 1'b1);
    step(4'b0000, 4'b0000, 2'd2, 1'b0);
    step(4'b0101, 4'b0001, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

    // asynchronous reset between edges while user 3 owns the bus
    step(4'b1000, 4'b1000, 2'd3, 1'b0);
    step(4'b1000, 4'b1000, 2'd3, 1'b1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_en", 32'(en), 32'h0);
    chk("async_busy", 32'(busy), 32'h0);
    chk("async_gid", 32'(grant_id), 32'h0);
    chk("async_bv", 32'(bus_valid), 32'h0);
    @(posedge clk);
    #1;
    chk("hold_rst_en", 32'(en), 32'h0);
    @(negedge clk);
    req   = 4'b0000;
    rst_n = 1'b1;
    step(4'b1111, 4'b0001, 2'd0, 1'b0);
    step(4'b1111, 4'b0001, 2'd0, 1'b1);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);
    step(4'b0000, 4'b0000, 2'd0, 1'b0);

`ifdef BUS_CAPTURE_EN
    dbus = 4'hA;
    step(4'b0010, 4'b0010, 2'd1, 1'b0);
    step(4'b0010, 4'b0010, 2'd1, 1'b1);
    step(4'b0000, 4'b0000, 2'd1, 1'b0);
    @(posedge clk);
    #2;
    chk("cap_valid_hi", 32'(cap_valid), 32'h1);
    chk("cap_data", 32'(cap_data), 32'hA);
    @(posedge clk);
    #2;
    chk("cap_valid_turn", 32'(cap_valid), 32'h0);
    chk("cap_data_hold", 32'(cap_data), 32'hA);
`endif

    // bounded drain of the scoreboard
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // One driver at most, sampled between edges.
  always @(negedge clk) begin
    if ($countones(en) > 1) begin
      failures++;
      $display("FAIL onehot en=%b want<=1 bit", en);
    end
  end

endmodule
